alu32_byte_seq: RTL and testbench

Sequencing initiator that performs a 32-bit ALU operation over four cycles using one external 8-bit ALU slice, one byte per cycle, least-significant byte first. Accepts an operation over a valid/ready request channel. Drives the slice's operands and controls each cycle, captures the byte result and carry, and chains the carry between cycles. Delivers the 32-bit result and flags over a valid/ready response channel. Sits between the datapath control and the combinational 8-bit slice in area-constrained builds.

---
 rtl/alu32_byte_seq.sv | 221 ++++++++++++++++++++++
 tb/tb_alu32_byte_seq.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu32_byte_seq.sv
// alu32_byte_seq: 32-bit ALU op sequenced over one 8-bit slice, LSB first.
// Build option ALU_SEQ_OVF_EN adds the overflow path and signed SLT.
module alu32_byte_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  input  logic [3:0]  ALU_control,
  output logic [7:0]  slice_src1,
  output logic [7:0]  slice_src2,
  output logic        slice_A_invert,
  output logic        slice_B_invert,
  output logic        slice_cin,
  output logic        slice_less,
  output logic [1:0]  slice_operation,
  input  logic [7:0]  slice_result,
  input  logic [7:0]  slice_cout,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        zero,
  output logic        cout,
  output logic        overflow
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  typedef enum logic [2:0] {
    OP_AND,
    OP_OR,
    OP_ADD,
    OP_SUB,
    OP_SLT,
    OP_NOR,
    OP_BAD
  } opk_t;

  state_t      state_q, state_d;
  opk_t        opk_q, opk_d;
  logic [1:0]  k_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [23:0] acc_q;
  logic        cin_q;
  logic [31:0] res_q, res_d;
  logic        zero_q, zero_d;
  logic        cout_q, cout_d;
  logic        ainv, binv;
  logic [1:0]  sop;
  logic        accept;
  logic        last;
  logic        raw_ovf;
  logic [31:0] full;
  logic        unused_ok;

`ifdef ALU_SEQ_OVF_EN
  logic        ovf_q, ovf_d;

  assign raw_ovf   = slice_cout[7] ^ slice_cout[6];
  assign overflow  = ovf_q;
  assign unused_ok = ^slice_cout[5:0];
`else
  assign raw_ovf   = 1'b0;
  assign overflow  = 1'b0;
  assign unused_ok = ^slice_cout[6:0];
`endif

  assign in_ready   = (state_q == S_IDLE);
  assign out_valid  = (state_q == S_DONE);
  assign accept     = in_ready && in_valid;
  assign last       = (state_q == S_RUN) && (k_q == 2'd3);
  assign slice_less = 1'b0;
  assign result     = res_q;
  assign zero       = zero_q;
  assign cout       = cout_q;

  // Classify the incoming operation code
  always_comb begin
    opk_d = OP_BAD;
    unique case (ALU_control)
      4'b0000: opk_d = OP_AND;
      4'b0001: opk_d = OP_OR;
      4'b0010: opk_d = OP_ADD;
      4'b0110: opk_d = OP_SUB;
      4'b0111: opk_d = OP_SLT;
      4'b1100: opk_d = OP_NOR;
      default: opk_d = OP_BAD;
    endcase
  end

  // Slice control decode for the latched operation
  always_comb begin
    ainv = 1'b0;
    binv = 1'b0;
    sop  = 2'b00;
    unique case (opk_q)
      OP_OR:  sop = 2'b01;
      OP_ADD: sop = 2'b10;
      OP_SUB,
      OP_SLT: begin
        binv = 1'b1;
        sop  = 2'b10;
      end
      OP_NOR: begin
        ainv = 1'b1;
        binv = 1'b1;
      end
      default: ;
    endcase
  end

  // Slice drive: current byte in RUN, all zero otherwise
  always_comb begin
    slice_src1      = 8'h00;
    slice_src2      = 8'h00;
    slice_A_invert  = 1'b0;
    slice_B_invert  = 1'b0;
    slice_cin       = 1'b0;
    slice_operation = 2'b00;
    if (state_q == S_RUN) begin
      slice_src1      = a_q[{k_q, 3'b000} +: 8];
      slice_src2      = b_q[{k_q, 3'b000} +: 8];
      slice_A_invert  = ainv;
      slice_B_invert  = binv;
      slice_cin       = (k_q == 2'd0) ? binv : cin_q;
      slice_operation = sop;
    end
  end

  // Final response from the last byte plus the accumulated bytes
  always_comb begin
    full   = {slice_result, acc_q};
    res_d  = full;
    cout_d = 1'b0;
`ifdef ALU_SEQ_OVF_EN
    ovf_d  = 1'b0;
`endif
    unique case (opk_q)
      OP_ADD,
      OP_SUB: begin
        cout_d = slice_cout[7];
`ifdef ALU_SEQ_OVF_EN
        ovf_d  = raw_ovf;
`endif
      end
      OP_SLT: res_d = {31'b0, full[31] ^ raw_ovf};
      OP_BAD: res_d = 32'h0;
      default: ;
    endcase
    zero_d = (res_d == 32'h0);
  end

  // Next-state logic for the request/run/response sequence
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (in_valid) state_d = S_RUN;
      S_RUN:  if (k_q == 2'd3) state_d = S_DONE;
      S_DONE: if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Operand latch, byte counter, carry chain and byte accumulator
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= 32'h0;
      b_q   <= 32'h0;
      opk_q <= OP_AND;
      k_q   <= 2'd0;
      cin_q <= 1'b0;
      acc_q <= 24'h0;
    end else if (accept) begin
      a_q   <= src1;
      b_q   <= src2;
      opk_q <= opk_d;
      k_q   <= 2'd0;
    end else if (state_q == S_RUN) begin
      k_q   <= k_q + 2'd1;
      cin_q <= slice_cout[7];
      unique case (k_q)
        2'd0: acc_q[7:0]   <= slice_result;
        2'd1: acc_q[15:8]  <= slice_result;
        2'd2: acc_q[23:16] <= slice_result;
        default: ;
      endcase
    end
  end

  // Registered response, held until the next completed operation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q  <= 32'h0;
      zero_q <= 1'b0;
      cout_q <= 1'b0;
`ifdef ALU_SEQ_OVF_EN
      ovf_q  <= 1'b0;
`endif
    end else if (last) begin
      res_q  <= res_d;
      zero_q <= zero_d;
      cout_q <= cout_d;
`ifdef ALU_SEQ_OVF_EN
      ovf_q  <= ovf_d;
`endif
    end
  end

endmodule

// File: tb/tb_alu32_byte_seq.sv
// tb_alu32_byte_seq: directed bench for alu32_byte_seq with an 8-bit
// slice model; expected values are hand-computed constants.
module tb_alu32_byte_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] src1;
  logic [31:0] src2;
  logic [3:0]  ALU_control;
  logic [7:0]  slice_src1;
  logic [7:0]  slice_src2;
  logic        slice_A_invert;
  logic        slice_B_invert;
  logic        slice_cin;
  logic        slice_less;
  logic [1:0]  slice_operation;
  logic [7:0]  slice_result;
  logic [7:0]  slice_cout;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        cout;
  logic        overflow;

  int total;
  int bad;
  int lat;

  logic [31:0] cs1, cs2;
  logic [3:0]  cai, cbi, ccin, cir;
  logic [7:0]  cop;
  logic [21:0] spk;

  localparam logic [3:0] C_AND = 4'b0000;
  localparam logic [3:0] C_OR  = 4'b0001;
  localparam logic [3:0] C_ADD = 4'b0010;
  localparam logic [3:0] C_SUB = 4'b0110;
  localparam logic [3:0] C_SLT = 4'b0111;
  localparam logic [3:0] C_NOR = 4'b1100;
  localparam logic [3:0] C_BAD = 4'b1010;

`ifdef ALU_SEQ_OVF_EN
  localparam logic [31:0] EXP_OVF  = 32'd1;
  localparam logic [31:0] EXP_SLT2 = 32'd1;
`else
  localparam logic [31:0] EXP_OVF  = 32'd0;
  localparam logic [31:0] EXP_SLT2 = 32'd0;
`endif

  alu32_byte_seq dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .src1            (src1),
    .src2            (src2),
    .ALU_control     (ALU_control),
    .slice_src1      (slice_src1),
    .slice_src2      (slice_src2),
    .slice_A_invert  (slice_A_invert),
    .slice_B_invert  (slice_B_invert),
    .slice_cin       (slice_cin),
    .slice_less      (slice_less),
    .slice_operation (slice_operation),
    .slice_result    (slice_result),
    .slice_cout      (slice_cout),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .result          (result),
    .zero            (zero),
    .cout            (cout),
    .overflow        (overflow)
  );

  assign spk = {slice_src1, slice_src2, slice_A_invert, slice_B_invert,
                slice_cin, slice_less, slice_operation};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational 8-bit slice with ripple carries
  logic [7:0] sa, sb;
  logic [8:0] cc;
  always_comb begin
    sa = slice_A_invert ? ~slice_src1 : slice_src1;
    sb = slice_B_invert ? ~slice_src2 : slice_src2;
    cc = '0;
    cc[0] = slice_cin;
    for (int i = 0; i < 8; i++)
      cc[i+1] = (sa[i] & sb[i]) | (sa[i] & cc[i]) | (sb[i] & cc[i]);
    slice_cout = cc[8:1];
    slice_result = 8'h00;
    case (slice_operation)
      2'b00: slice_result = sa & sb;
      2'b01: slice_result = sa | sb;
      2'b10: slice_result = sa ^ sb ^ cc[7:0];
      default: slice_result = {7'b0, slice_less};
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [3:0] op, input logic [31:0] a,
                      input logic [31:0] b);
    @(negedge clk);
    chk("in_ready_idle", {31'b0, in_ready}, 32'd1);
    in_valid    = 1'b1;
    ALU_control = op;
    src1        = a;
    src2        = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    lat = 0;
    while (!out_valid && lat < 12) begin
      if (lat < 4) begin
        cs1[lat*8 +: 8] = slice_src1;
        cs2[lat*8 +: 8] = slice_src2;
        cai[lat]        = slice_A_invert;
        cbi[lat]        = slice_B_invert;
        ccin[lat]       = slice_cin;
        cir[lat]        = in_ready;
        cop[lat*2 +: 2] = slice_operation;
      end
      @(posedge clk);
      #1;
      lat++;
    end
    chk("done_edge", lat, 32'd4);
  endtask

  task automatic run_op(input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b);
    send(op, a, b);
    wait_done();
  endtask

  task automatic ack();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("ack_idle", {30'b0, out_valid, in_ready}, 32'b01);
    chk("idle_slice", {10'b0, spk}, 32'h0);
  endtask

  initial begin
    total       = 0;
    bad         = 0;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    src1        = 32'h0;
    src2        = 32'h0;
    ALU_control = 4'h0;
    cs1 = '0; cs2 = '0; cai = '0; cbi = '0;
    ccin = '0; cir = '0; cop = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_hs", {30'b0, in_ready, out_valid}, 32'b10);
    chk("rst_result", result, 32'h0);
    chk("rst_flags", {29'b0, zero, cout, overflow}, 32'h0);
    chk("rst_slice", {10'b0, spk}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(C_ADD, 32'h7FFF_FFFF, 32'h0000_0001);
    chk("add_result", result, 32'h8000_0000);
    chk("add_ovf", {31'b0, overflow}, EXP_OVF);
    chk("add_cout_zero", {30'b0, cout, zero}, 32'b00);
    chk("add_bytes_a", cs1, 32'h7FFF_FFFF);
    chk("add_bytes_b", cs2, 32'h0000_0001);
    chk("add_cin_chain", {28'b0, ccin}, 32'b1110);
    chk("run_in_ready", {28'b0, cir}, 32'h0);
    chk("done_slice", {10'b0, spk}, 32'h0);
    ack();

    run_op(C_SUB, 32'h0000_0005, 32'h0000_0005);
    chk("sub_result", result, 32'h0);
    chk("sub_flags", {29'b0, zero, cout, overflow}, 32'b110);
    chk("sub_cin0", {31'b0, ccin[0]}, 32'd1);
    chk("sub_ctl0", {29'b0, cai[0], cop[1:0]}, 32'b010);
    chk("sub_binv", {28'b0, cbi}, 32'hF);
    ack();

    run_op(C_SLT, 32'hFFFF_FFFF, 32'h0000_0001);
    chk("slt_neg", result, 32'd1);
    chk("slt_neg_flags", {29'b0, zero, cout, overflow}, 32'b000);
    ack();

    run_op(C_SLT, 32'h8000_0000, 32'h0000_0001);
    chk("slt_ovf", result, EXP_SLT2);
    chk("slt_ovf_zero", {31'b0, zero}, {31'b0, ~EXP_SLT2[0]});
    chk("slt_ovf_cv", {30'b0, cout, overflow}, 32'b00);
    ack();

    run_op(C_NOR, 32'h0000_0000, 32'h00FF_00FF);
    chk("nor_result", result, 32'hFF00_FF00);
    chk("nor_ainv", {28'b0, cai}, 32'hF);
    chk("nor_binv", {28'b0, cbi}, 32'hF);
    chk("nor_op", {24'b0, cop}, 32'h0);
    chk("nor_flags", {29'b0, zero, cout, overflow}, 32'b000);
    ack();

    run_op(C_AND, 32'hF0F0_1234, 32'h0FF0_FF00);
    chk("and_result", result, 32'h00F0_1200);
    chk("and_op", {24'b0, cop}, 32'h0);
    ack();

    run_op(C_OR, 32'h1234_0000, 32'h0000_5678);
    chk("or_result", result, 32'h1234_5678);
    chk("or_op", {24'b0, cop}, 32'h55);
    chk("or_flags", {29'b0, zero, cout, overflow}, 32'b000);
    ack();

    run_op(C_ADD, 32'hFFFF_FFFF, 32'h0000_0001);
    chk("add_wrap_result", result, 32'h0);
    chk("add_wrap_flags", {29'b0, zero, cout, overflow}, 32'b110);
    ack();

    run_op(C_ADD, 32'h0000_00FF, 32'h0000_0001);
    chk("add_chain", result, 32'h0000_0100);
    ack();

    run_op(C_BAD, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("bad_result", result, 32'h0);
    chk("bad_flags", {29'b0, zero, cout, overflow}, 32'b100);
    chk("bad_ctl", {20'b0, cai, cbi, cop[7:4]}, 32'h0);
    chk("bad_ctl_lo", {28'b0, cop[3:0]}, 32'h0);
    chk("bad_cin0", {31'b0, ccin[0]}, 32'd0);
    ack();

    run_op(C_ADD, 32'h1111_1111, 32'h2222_2222);
    in_valid    = 1'b1;
    ALU_control = C_SUB;
    src1        = 32'h0000_0010;
    src2        = 32'h0000_0003;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("bp_result", result, 32'h3333_3333);
      chk("bp_flags", {29'b0, zero, cout, overflow}, 32'b000);
      chk("bp_hs", {30'b0, out_valid, in_ready}, 32'b10);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("bp_no_accept", {30'b0, out_valid, in_ready}, 32'b01);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("bp_accept", {31'b0, in_ready}, 32'd0);
    wait_done();
    chk("bp_next_result", result, 32'h0000_000D);
    chk("bp_next_flags", {29'b0, zero, cout, overflow}, 32'b010);
    ack();

    send(C_ADD, 32'h0102_0304, 32'h1020_3040);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("pre_rst_byte2", {24'b0, slice_src1}, 32'h02);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_hs", {30'b0, in_ready, out_valid}, 32'b10);
    chk("arst_result", result, 32'h0);
    chk("arst_flags", {29'b0, zero, cout, overflow}, 32'h0);
    chk("arst_slice", {10'b0, spk}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("arst_no_resp", {31'b0, out_valid}, 32'd0);

    run_op(C_ADD, 32'h0102_0304, 32'h1020_3040);
    chk("post_rst_result", result, 32'h1122_3344);
    chk("post_rst_flags", {29'b0, zero, cout, overflow}, 32'b000);
    ack();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
